// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one request outstanding to imem, applies redirects
// and drops wrong-path responses. Define FETCH_MISALIGN_TRAP_EN to trap on misaligned redirect targets.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCSrc,
  input  logic        Jalr,
  input  logic [31:0] ExecPC,
  input  logic [31:0] ImmExt,
  input  logic [31:0] ALUResult,
  input  logic        Stall,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemValid,
  input  logic [31:0] IMemRData,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        InstrValidD,
  output logic        MisalignTrap,
  output logic [31:0] MisalignAddr,
  output logic [2:0]  state_dbg
);

  // Handshakes: InstrValidD (valid) / ~Stall (ready) to decode; a transfer happens in any cycle
  // where both are high, and InstrD/PCD/PCPlus4D stay stable while valid is high and ready is low.
  // IMemReq has no ready: memory accepts every request, answering later with an IMemValid strobe.
  typedef enum logic [2:0] {
    S_REQ  = 3'd0,
    S_WAIT = 3'd1,
    S_HOLD = 3'd2,
    S_DROP = 3'd3
`ifdef FETCH_MISALIGN_TRAP_EN
    , S_TRAP = 3'd4
`endif
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_plus4, raw_target, target;
  logic        redirect, req_c;

  assign pc_plus4   = pc + 32'd4;
  assign raw_target = Jalr ? (ALUResult & 32'hFFFF_FFFE) : (ExecPC + ImmExt);

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned;
  assign target     = raw_target;
  assign misaligned = (raw_target[1:0] != 2'b00);
  // Once trapped, the unit is frozen until reset.
  assign redirect   = PCSrc && (state != S_TRAP);
`else
  assign target     = raw_target & 32'hFFFF_FFFC;
  assign redirect   = PCSrc;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_REQ;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    req_c   = 1'b0;
    case (state)
      S_REQ: begin
        if (!redirect) begin
          req_c   = 1'b1;
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect)       state_n = IMemValid ? S_REQ : S_DROP;
        else if (IMemValid) state_n = S_HOLD;
      end
      S_HOLD: begin
        if (redirect) state_n = S_REQ;
        else if (!Stall) begin
          req_c   = 1'b1;
          state_n = S_WAIT;
        end
      end
      // A response arriving together with a new redirect still retires the stale request.
      S_DROP: begin
        if (IMemValid) state_n = S_REQ;
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      S_TRAP: state_n = S_TRAP;
`endif
      default: state_n = S_REQ;
    endcase
`ifdef FETCH_MISALIGN_TRAP_EN
    if (redirect && misaligned) state_n = S_TRAP;
`endif
  end

  assign IMemReq   = req_c & reset;
  assign IMemAddr  = pc;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      InstrD      <= 32'h0000_0013;
      PCD         <= 32'h0;
      PCPlus4D    <= 32'h0;
      InstrValidD <= 1'b0;
    end else if (redirect) begin
      pc          <= target;
      InstrValidD <= 1'b0;
    end else if (state == S_WAIT && IMemValid) begin
      InstrD      <= IMemRData;
      PCD         <= pc;
      PCPlus4D    <= pc_plus4;
      InstrValidD <= 1'b1;
      pc          <= pc_plus4;
    end else if (state == S_HOLD && !Stall) begin
      InstrValidD <= 1'b0;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      MisalignTrap <= 1'b0;
      MisalignAddr <= 32'h0;
    end else if (redirect && misaligned) begin
      MisalignTrap <= 1'b1;
      MisalignAddr <= target;
    end
  end
`else
  assign MisalignTrap = 1'b0;
  assign MisalignAddr = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed timing scenarios, then randomized stall/redirect/latency traffic
// checked by a scoreboard holding the expected sequential fetch stream.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        PCSrc = 1'b0, Jalr = 1'b0, Stall = 1'b0, IMemValid = 1'b0;
  logic [31:0] ExecPC = '0, ImmExt = '0, ALUResult = '0, IMemRData = '0;
  logic        IMemReq, InstrValidD, MisalignTrap;
  logic [31:0] IMemAddr, InstrD, PCD, PCPlus4D, MisalignAddr;
  logic [2:0]  state_dbg;

  int n_checks = 0, n_errors = 0, consumed = 0;
  int lat_mode = 1;                 // 0 = random 1..4 cycles, else fixed latency
  logic        mem_pend = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_cnt = 0;
  logic [31:0] exp_q[$];            // expected PCs of upcoming consumed instructions

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .PCSrc(PCSrc), .Jalr(Jalr), .ExecPC(ExecPC), .ImmExt(ImmExt),
    .ALUResult(ALUResult), .Stall(Stall), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
    .IMemValid(IMemValid), .IMemRData(IMemRData), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .InstrValidD(InstrValidD), .MisalignTrap(MisalignTrap),
    .MisalignAddr(MisalignAddr), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000 ^ {a[7:0], 24'h0};
  endfunction

  function automatic logic [31:0] model_target(input logic j, input logic [31:0] epc,
                                               input logic [31:0] imm, input logic [31:0] alu);
    logic [31:0] t;
    t = j ? (alu & ~32'h1) : (epc + imm);
`ifndef FETCH_MISALIGN_TRAP_EN
    t = t & ~32'h3;
`endif
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic restart(input logic [31:0] a);
    exp_q.delete();
    for (int i = 0; i < 128; i++) exp_q.push_back(a + 32'(4 * i));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    chk1("rst_req", IMemReq, 1'b0);
    chk("rst_addr", IMemAddr, RESET_PC);
    chk1("rst_valid", InstrValidD, 1'b0);
    chk("rst_instr", InstrD, 32'h0000_0013);
    chk("rst_pcd", PCD, 32'h0);
    chk("rst_pcplus4", PCPlus4D, 32'h0);
    chk1("rst_trap", MisalignTrap, 1'b0);
    chk("rst_maddr", MisalignAddr, 32'h0);
  endtask

  // One-cycle PCSrc pulse; called at cycle start, returns at the next cycle start.
  task automatic redirect(input logic j, input logic [31:0] epc, input logic [31:0] imm,
                          input logic [31:0] alu);
    logic [31:0] t;
    Jalr = j; ExecPC = epc; ImmExt = imm; ALUResult = alu; PCSrc = 1'b1;
    t = model_target(j, epc, imm, alu);
`ifdef FETCH_MISALIGN_TRAP_EN
    if (t[1:0] == 2'b00) restart(t);
    else exp_q.delete();
`else
    restart(t);
`endif
    @(negedge clk);
    chk1("req_blocked_on_redirect", IMemReq, 1'b0);
    tick();
    PCSrc = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    restart(RESET_PC);
    repeat (2) begin @(negedge clk); tick(); end
    reset = 1'b1;
  endtask

  // ---------------- memory model ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) mem_pend = 1'b0;
      else if (IMemReq) begin
        chk1("one_outstanding", mem_pend, 1'b0);
        mem_pend = 1'b1;
        mem_addr = IMemAddr;
        mem_cnt  = (lat_mode == 0) ? $urandom_range(1, 4) : lat_mode;
      end
      @(posedge clk);
      #1;
      IMemValid = 1'b0;
      IMemRData = $urandom;
      if (!reset) mem_pend = 1'b0;
      else if (mem_pend) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          IMemValid = 1'b1;
          IMemRData = mem_word(mem_addr);
          mem_pend  = 1'b0;
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (reset && InstrValidD && !Stall && !PCSrc) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_instr: got pc %h, expected no instruction", PCD);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pcd", PCD, e);
          chk("sb_pcplus4", PCPlus4D, e + 32'd4);
          chk("sb_instr", InstrD, mem_word(e));
          consumed++;
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    n_errors++;
    $display("FAIL watchdog: got timeout, expected completion (state %0d)", state_dbg);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // ---------------- directed then random stimulus ----------------
  initial begin : main
    logic        found;
    logic [31:0] r1, r2, r3;
    restart(RESET_PC);
    repeat (3) @(negedge clk);
    check_reset_vals();

    // Zero-wait memory, no stall: requests every 2 cycles.
    tick(); reset = 1'b1;                                   // cycle 0
    @(negedge clk); chk1("c0_req", IMemReq, 1'b1); chk("c0_addr", IMemAddr, RESET_PC);
    tick(); @(negedge clk); chk1("c1_req", IMemReq, 1'b0);
    tick(); @(negedge clk);                                 // cycle 2
    chk1("c2_req", IMemReq, 1'b1); chk("c2_addr", IMemAddr, RESET_PC + 32'd4);
    chk1("c2_valid", InstrValidD, 1'b1); chk("c2_pcd", PCD, RESET_PC);
    chk("c2_pcplus4", PCPlus4D, RESET_PC + 32'd4); chk("c2_instr", InstrD, mem_word(RESET_PC));
    tick(); @(negedge clk); chk1("c3_req", IMemReq, 1'b0);
    tick(); @(negedge clk); chk1("c4_req", IMemReq, 1'b1); chk("c4_addr", IMemAddr, RESET_PC + 32'd8);

    // Stall held for 3 HOLD cycles.
    tick(); Stall = 1'b1;                                   // cycle 5
    for (int k = 0; k < 3; k++) begin
      tick(); @(negedge clk);
      chk1("stall_req", IMemReq, 1'b0); chk1("stall_valid", InstrValidD, 1'b1);
      chk("stall_pcd", PCD, RESET_PC + 32'd8); chk("stall_instr", InstrD, mem_word(RESET_PC + 32'd8));
    end
    tick(); Stall = 1'b0; lat_mode = 4;                     // cycle 9
    @(negedge clk); chk1("resume_req", IMemReq, 1'b1); chk("resume_addr", IMemAddr, RESET_PC + 32'd12);

    // Branch during WAIT, response 3 cycles later is dropped.
    tick(); redirect(1'b0, 32'h100, 32'hFFFF_FFF0, 32'h0);  // cycle 10
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk1("drop_req", IMemReq, 1'b0); chk1("drop_valid", InstrValidD, 1'b0);
      tick();
    end
    lat_mode = 1;
    @(negedge clk); chk1("redir_req", IMemReq, 1'b1); chk("redir_addr", IMemAddr, 32'hF0);

    // Redirect coinciding with the response in WAIT.
    tick(); redirect(1'b0, 32'h30, 32'h10, 32'h0);
    @(negedge clk);
    chk1("same_cycle_req", IMemReq, 1'b1); chk("same_cycle_addr", IMemAddr, 32'h40);
    chk1("same_cycle_valid", InstrValidD, 1'b0);

    // Jalr redirect while holding a stalled instruction.
    tick(); Stall = 1'b1; @(negedge clk);
    tick(); @(negedge clk);
    chk1("jalr_hold_valid", InstrValidD, 1'b1); chk("jalr_hold_pcd", PCD, 32'h40);
    tick(); redirect(1'b1, 32'h0, 32'h0, 32'h203);
    Stall = 1'b0;
    @(negedge clk);
    chk1("jalr_valid", InstrValidD, 1'b0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk1("trap_set", MisalignTrap, 1'b1); chk("trap_addr", MisalignAddr, 32'h202);
    chk1("trap_req", IMemReq, 1'b0);
    tick(); redirect(1'b0, 32'h300, 32'h0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("trap_hold_req", IMemReq, 1'b0); chk("trap_hold_addr", MisalignAddr, 32'h202);
      chk1("trap_hold_valid", InstrValidD, 1'b0);
      tick();
    end
    apply_reset();
`else
    chk1("jalr_req", IMemReq, 1'b1); chk("jalr_addr", IMemAddr, 32'h200);
`endif

    // Reset asserted while dropping an outstanding response.
    tick(); lat_mode = 4;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (IMemReq) found = 1'b1;
      else tick();
    end
    chk1("find_req", found, 1'b1);
    tick(); redirect(1'b0, 32'h80, 32'h0, 32'h0);
    reset = 1'b0; restart(RESET_PC); lat_mode = 1;
    @(negedge clk); check_reset_vals();
    tick(); @(negedge clk);
    tick(); reset = 1'b1;
    @(negedge clk); chk1("post_reset_req", IMemReq, 1'b1); chk("post_reset_addr", IMemAddr, RESET_PC);

    // Randomized traffic.
    tick(); lat_mode = 0;
    repeat (3000) begin
      Stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) begin
        r1 = $urandom; r2 = $urandom; r3 = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
        r1 = r1 & ~32'h3;
        r2 = (r2 & 32'h3FC) - 32'h200;
        r3 = r3 & ~32'h2;
`endif
        redirect(1'($urandom_range(0, 1)), r1, r2, r3);
      end else begin
        @(negedge clk);
        tick();
      end
    end
    Stall = 1'b0;
    repeat (20) begin @(negedge clk); tick(); end
    chk1("progress", consumed > 100, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
